// File: rtl/uart_imem_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader.
//   loader_state_e : top-level load sequencer states
//   rx_state_e     : serial receiver states
//   ERR_*          : err_code values reported by the loader
package uart_imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_DONE,
        ST_ERR
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_FRAMING = 2'd1;
    localparam logic [1:0] ERR_LENGTH  = 2'd2;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver.
//   clk_i       : system clock
//   rst_i       : synchronous active-high reset
//   rx_i        : asynchronous serial input, idle high
//   rx_valid_o  : one-cycle pulse, rx_byte_o holds a good byte
//   rx_byte_o   : received byte
//   rx_ferr_o   : one-cycle pulse, stop bit was sampled low
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | half-bit wait, then confirm start bit is still low
// RX_DATA  | sampling 8 data bits, LSB first
// RX_STOP  | sampling stop bit
module uart_rx_byte
    import uart_imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_byte_o,
    output logic       rx_ferr_o
);

    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(CLKS_PER_BIT - 1);

    rx_state_e        state_q, state_d;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             tmr_tc;

    assign tmr_tc = (tmr_q == '0);

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    tmr_d   = TMR_HALF;
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (!tmr_tc) begin
                    tmr_d = tmr_q - 1'b1;
                end else if (rx_sync_q) begin
                    // line went back high by mid-bit: treat as a glitch
                    state_d = RX_IDLE;
                end else begin
                    tmr_d     = TMR_FULL;
                    bit_idx_d = '0;
                    state_d   = RX_DATA;
                end
            end
            RX_DATA: begin
                if (!tmr_tc) begin
                    tmr_d = tmr_q - 1'b1;
                end else begin
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    tmr_d     = TMR_FULL;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (!tmr_tc) begin
                    tmr_d = tmr_q - 1'b1;
                end else begin
                    valid_d = rx_sync_q;
                    ferr_d  = !rx_sync_q;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RX_IDLE;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            tmr_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            tmr_q     <= tmr_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rx_valid_o = valid_q;
    assign rx_ferr_o  = ferr_q;
    assign rx_byte_o  = shift_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Loads a program image received over UART into instruction memory and holds
// the CPU in reset while loading or after a failed load.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   start_i        : one-cycle pulse, arms a new load
//   uart_rx_i      : serial input, idle high
//   imem_we_o      : one-cycle write strobe
//   imem_addr_o    : word address of write
//   imem_wdata_o   : word to write
//   cpu_hold_o     : keep CPU in reset (busy or error)
//   busy_o         : load in progress
//   done_o         : sticky, last load completed
//   err_o          : sticky, last load aborted
//   err_code_o     : ERR_NONE / ERR_FRAMING / ERR_LENGTH
//
// state   | meaning
// ST_IDLE | no load since reset
// ST_LEN0 | waiting for word count low byte
// ST_LEN1 | waiting for word count high byte, then length check
// ST_DATA | assembling and writing words
// ST_DONE | image complete, CPU released
// ST_ERR  | load aborted, CPU held
module uart_imem_loader
    import uart_imem_loader_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 23_000_000,
    parameter int BAUD        = 115_200,
    parameter int ADDR_W      = 14
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              uart_rx_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_W);

    logic       rx_valid, rx_ferr;
    logic [7:0] rx_byte;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rx_i      (uart_rx_i),
        .rx_valid_o(rx_valid),
        .rx_byte_o (rx_byte),
        .rx_ferr_o (rx_ferr)
    );

    loader_state_e     state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       word_buf_q, word_buf_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [16:0]       n_full;

    assign n_full = {1'b0, rx_byte, len_lo_q};

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        n_d        = n_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        word_buf_d = word_buf_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_code_d = err_code_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) begin
                    state_d    = ST_LEN0;
                    err_code_d = ERR_NONE;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    word_buf_d = '0;
                end
            end
            ST_LEN0: begin
                if (rx_ferr) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_FRAMING;
                end else if (rx_valid) begin
                    len_lo_d = rx_byte;
                    state_d  = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (rx_ferr) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_FRAMING;
                end else if (rx_valid) begin
                    if (n_full == '0) begin
                        state_d = ST_DONE;
                    end else if (n_full > CAPACITY) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_LENGTH;
                    end else begin
                        n_d     = n_full[ADDR_W:0];
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_ferr) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_FRAMING;
                end else if (we_q && word_cnt_q == n_q) begin
                    // final word strobed this cycle; word_cnt already advanced
                    state_d = ST_DONE;
                end else if (rx_valid) begin
                    case (byte_cnt_q)
                        2'd0:    word_buf_d[7:0]   = rx_byte;
                        2'd1:    word_buf_d[15:8]  = rx_byte;
                        2'd2:    word_buf_d[23:16] = rx_byte;
                        default: word_buf_d[31:24] = rx_byte;
                    endcase
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        addr_d     = word_cnt_q[ADDR_W-1:0];
                        wdata_d    = {rx_byte, word_buf_q[23:0]};
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            len_lo_q   <= '0;
            n_q        <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            word_buf_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            n_q        <= n_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            word_buf_q <= word_buf_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_code_q <= err_code_d;
        end
    end

    assign busy_o       = (state_q == ST_LEN0) || (state_q == ST_LEN1) || (state_q == ST_DATA);
    assign done_o       = (state_q == ST_DONE);
    assign err_o        = (state_q == ST_ERR);
    assign cpu_hold_o   = busy_o || err_o;
    assign err_code_o   = err_code_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
module tb_uart_imem_loader;

    localparam int ADDR_W = 4;
    localparam int CPB    = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              uart_rx;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold, busy, done, err;
    logic [1:0]        err_code;

    int n_checks = 0;
    int n_fails  = 0;

    uart_imem_loader #(
        .CLK_FREQ_HZ(1_000_000),
        .BAUD       (100_000),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .uart_rx_i   (uart_rx),
        .imem_we_o   (imem_we),
        .imem_addr_o (imem_addr),
        .imem_wdata_o(imem_wdata),
        .cpu_hold_o  (cpu_hold),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .err_code_o  (err_code)
    );

    always #5 clk = ~clk;

    // write monitor, sampled mid-cycle
    int          cyc = 0;
    int          we_cnt = 0;
    int          last_we_cyc = 0;
    int          done_rise_cyc = 0;
    logic        done_prev = 1'b0;
    logic [31:0] wr_addr [32];
    logic [31:0] wr_data [32];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (imem_we === 1'b1) begin
            wr_addr[we_cnt % 32] = 32'(imem_addr);
            wr_data[we_cnt % 32] = imem_wdata;
            we_cnt      = we_cnt + 1;
            last_we_cyc = cyc;
        end
        if (done === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
        done_prev = done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_not_busy(input string tag);
        int i;
        i = 0;
        while (busy === 1'b1 && i < 60) begin
            @(negedge clk);
            i++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    int base;

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // two-word image, with a stray start mid-load that must be ignored
        base = we_cnt;
        pulse_start();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_hold", {31'd0, cpu_hold}, 32'd1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        pulse_start();
        send_byte(8'h05, 1'b1);
        send_byte(8'hA0, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h93, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'hF0, 1'b1);
        send_byte(8'hFF, 1'b1);
        wait_not_busy("t1_timeout");
        chk("t1_nwr", 32'(we_cnt - base), 32'd2);
        chk("t1_addr0", wr_addr[base % 32], 32'd0);
        chk("t1_data0", wr_data[base % 32], 32'h00A00513);
        chk("t1_addr1", wr_addr[(base + 1) % 32], 32'd1);
        chk("t1_data1", wr_data[(base + 1) % 32], 32'hFFF00593);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_hold_rel", {31'd0, cpu_hold}, 32'd0);
        chk("t1_err", {31'd0, err}, 32'd0);
        chk("t1_done_lat", 32'(done_rise_cyc - last_we_cyc), 32'd1);
        chk("t1_addr_hold", 32'(imem_addr), 32'd1);
        chk("t1_wdata_hold", imem_wdata, 32'hFFF00593);
        chk("t1_we_low", {31'd0, imem_we}, 32'd0);

        // empty image
        base = we_cnt;
        pulse_start();
        chk("t2_done_clr", {31'd0, done}, 32'd0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_not_busy("t2_timeout");
        chk("t2_nwr", 32'(we_cnt - base), 32'd0);
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_hold", {31'd0, cpu_hold}, 32'd0);

        // oversize image (17 > 16 words)
        base = we_cnt;
        pulse_start();
        send_byte(8'h11, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_not_busy("t3_timeout");
        chk("t3_err", {31'd0, err}, 32'd1);
        chk("t3_code", 32'(err_code), 32'd2);
        chk("t3_hold", {31'd0, cpu_hold}, 32'd1);
        chk("t3_done", {31'd0, done}, 32'd0);
        chk("t3_nwr", 32'(we_cnt - base), 32'd0);

        // framing error inside a word, then a good reload
        base = we_cnt;
        pulse_start();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b0);
        wait_not_busy("t4_timeout");
        chk("t4_err", {31'd0, err}, 32'd1);
        chk("t4_code", 32'(err_code), 32'd1);
        chk("t4_hold", {31'd0, cpu_hold}, 32'd1);
        chk("t4_nwr", 32'(we_cnt - base), 32'd0);
        pulse_start();
        chk("t4_err_clr", {31'd0, err}, 32'd0);
        chk("t4_code_clr", 32'(err_code), 32'd0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hDE, 1'b1);
        wait_not_busy("t4r_timeout");
        chk("t4r_nwr", 32'(we_cnt - base), 32'd1);
        chk("t4r_addr", wr_addr[base % 32], 32'd0);
        chk("t4r_data", wr_data[base % 32], 32'hDEADBEEF);
        chk("t4r_done", {31'd0, done}, 32'd1);
        chk("t4r_hold", {31'd0, cpu_hold}, 32'd0);

        // short glitch on the line while waiting for the length
        base = we_cnt;
        pulse_start();
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("t5_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        wait_not_busy("t5_timeout");
        chk("t5_nwr", 32'(we_cnt - base), 32'd1);
        chk("t5_data", wr_data[base % 32], 32'h12345678);
        chk("t5_done", {31'd0, done}, 32'd1);

        // reset in the middle of a load
        pulse_start();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_hold", {31'd0, cpu_hold}, 32'd0);
        chk("t6_done", {31'd0, done}, 32'd0);
        chk("t6_err", {31'd0, err}, 32'd0);
        chk("t6_addr", 32'(imem_addr), 32'd0);
        chk("t6_wdata", imem_wdata, 32'd0);
        base = we_cnt;
        @(negedge clk);
        pulse_start();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h11, 1'b1);
        wait_not_busy("t6r_timeout");
        chk("t6r_nwr", 32'(we_cnt - base), 32'd1);
        chk("t6r_addr", wr_addr[base % 32], 32'd0);
        chk("t6r_data", wr_data[base % 32], 32'h11223344);
        chk("t6r_done", {31'd0, done}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
